// File: rtl/misr_pkg.sv
// misr_pkg: shared types and helpers for the MISR output response analyser.
//   misr_state_e  : FSM states (IDLE, RUN, DONE)
//   misr_next()   : one Galois-MISR compaction step on a zero-extended vector
//   default_poly(): default feedback tap masks per signature width
package misr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } misr_state_e;

    // Upper bound on WIDTH; the helper works on vectors of this size and the
    // caller keeps the low WIDTH bits.
    localparam int MISR_MAX_W = 64;

    localparam logic [3:0]  POLY_W4  = 4'b0011;   // x^4 + x + 1
    localparam logic [7:0]  POLY_W8  = 8'h1D;     // x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [15:0] POLY_W16 = 16'h002D;  // x^16 + x^5 + x^3 + x^2 + 1

    function automatic logic [MISR_MAX_W-1:0] default_poly(input int width);
        logic [MISR_MAX_W-1:0] p;
        case (width)
            8:       p = MISR_MAX_W'(POLY_W8);
            16:      p = MISR_MAX_W'(POLY_W16);
            default: p = MISR_MAX_W'(POLY_W4);
        endcase
        return p;
    endfunction

    // s[i] <= s[i-1] ^ (poly[i] & msb) ^ din[i], with s[-1] = 0 and din bits
    // above din_w treated as 0. Bits at or above width are returned as 0.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] s,
        input logic [MISR_MAX_W-1:0] din,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    width,
        input int                    din_w
    );
        logic [MISR_MAX_W-1:0] r;
        logic                  m;
        r    = '0;
        m    = s[width-1];
        r[0] = (poly[0] & m) ^ ((din_w > 0) ? din[0] : 1'b0);
        for (int i = 1; i < MISR_MAX_W; i++) begin
            if (i < width) begin
                r[i] = s[i-1] ^ (poly[i] & m) ^ ((i < din_w) ? din[i] : 1'b0);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/misr_ora_param_core.sv
// misr_core: signature register plus next-state XOR network.
//   clock, reset (async, active-low)
//   load      : reload SEED (has priority over enable)
//   enable    : compact din this cycle
//   din       : DIN_W-bit response, bit i feeds stage i
//   signature : WIDTH-bit register contents
module misr_core
    import misr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               DIN_W = 2,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [DIN_W-1:0] din,
    output logic [WIDTH-1:0] signature
);

    logic [MISR_MAX_W-1:0] next_full;
    logic [WIDTH-1:0]      next_sig;

    assign next_full = misr_next(MISR_MAX_W'(signature), MISR_MAX_W'(din),
                                 MISR_MAX_W'(POLY), WIDTH, DIN_W);
    assign next_sig  = next_full[WIDTH-1:0];

    // Upper bits of the helper result are always zero.
    if (WIDTH < MISR_MAX_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^next_full[MISR_MAX_W-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            signature <= SEED;
        end else if (load) begin
            signature <= SEED;
        end else if (enable) begin
            signature <= next_sig;
        end
    end

endmodule

// File: rtl/misr_ora_param.sv
// misr_ora_param: parametrised MISR output response analyser.
// Compacts NUM_PATTERNS valid responses into a WIDTH-bit Galois MISR, then
// freezes the signature and compares it against golden.
//   reset (async, active-low), clock
//   start, din_valid, din[DIN_W], golden[WIDTH]
//   signature[WIDTH], busy, done, pass, pattern_cnt
// Optional: MISR_XMASK_EN adds din_mask[DIN_W]; masked bits compact as 0.
//
// state | meaning
// IDLE  | waiting for start, signature holds
// RUN   | compacting valid responses, busy=1
// DONE  | signature frozen, done=1, pass reflects compare with golden
module misr_ora_param
    import misr_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter int               DIN_W        = 2,
    parameter logic [WIDTH-1:0] POLY         = WIDTH'(default_poly(WIDTH)),
    parameter logic [WIDTH-1:0] SEED         = '0,
    parameter int               NUM_PATTERNS = 16,
    localparam int              CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
    input  logic             reset,
    input  logic             clock,
    input  logic             start,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] din,
`ifdef MISR_XMASK_EN
    input  logic [DIN_W-1:0] din_mask,
`endif
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pattern_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_PATTERNS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PATTERNS - 1);

    misr_state_e      state;
    logic             core_load;
    logic             core_enable;
    logic [DIN_W-1:0] din_eff;

`ifdef MISR_XMASK_EN
    assign din_eff = din & ~din_mask;
`else
    assign din_eff = din;
`endif

    // start outside RUN wins over din_valid, so a reseed never compacts.
    assign core_load   = start && (state != RUN);
    assign core_enable = (state == RUN) && din_valid;

    misr_core #(
        .WIDTH (WIDTH),
        .DIN_W (DIN_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .load      (core_load),
        .enable    (core_enable),
        .din       (din_eff),
        .signature (signature)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pattern_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        pattern_cnt <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (din_valid) begin
                        if (pattern_cnt != CNT_MAX) begin
                            pattern_cnt <= pattern_cnt + CNT_W'(1);
                        end
                        if (pattern_cnt == CNT_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Live golden against the frozen signature.
    assign pass = done && (signature == golden);

endmodule

// File: tb/tb_misr_ora_param.sv
module tb_misr_ora_param;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // dut0: SEED=0, 4 patterns; dut1: SEED=0001, 8 patterns
    logic       start0 = 0, dv0 = 0;
    logic [1:0] din0 = '0, mask0 = '0;
    logic [3:0] golden0 = '0, sig0;
    logic       busy0, done0, pass0;
    logic [2:0] cnt0;

    logic       start1 = 0, dv1 = 0;
    logic [1:0] din1 = '0, mask1 = '0;
    logic [3:0] golden1 = '0, sig1;
    logic       busy1, done1, pass1;
    logic [3:0] cnt1;

    misr_ora_param #(.WIDTH(4), .DIN_W(2), .POLY(4'b0011), .SEED(4'b0000), .NUM_PATTERNS(4)) dut0 (
        .reset(reset), .clock(clock), .start(start0), .din_valid(dv0), .din(din0),
`ifdef MISR_XMASK_EN
        .din_mask(mask0),
`endif
        .golden(golden0), .signature(sig0), .busy(busy0), .done(done0), .pass(pass0),
        .pattern_cnt(cnt0)
    );

    misr_ora_param #(.WIDTH(4), .DIN_W(2), .POLY(4'b0011), .SEED(4'b0001), .NUM_PATTERNS(8)) dut1 (
        .reset(reset), .clock(clock), .start(start1), .din_valid(dv1), .din(din1),
`ifdef MISR_XMASK_EN
        .din_mask(mask1),
`endif
        .golden(golden1), .signature(sig1), .busy(busy1), .done(done1), .pass(pass1),
        .pattern_cnt(cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: 0=idle, 1=run, 2=done
    int         mstate[2];
    logic [3:0] msig[2];
    int         mcnt[2];
    logic [3:0] seed_of[2];
    int         np_of[2];

    // Multiply the signature polynomial by x modulo x^4+x+1, then add din.
    function automatic logic [3:0] mstep(input logic [3:0] s, input logic [1:0] d);
        logic [4:0] t;
        t = {s, 1'b0};
        if (t[4]) t = t ^ 5'b10011;
        return t[3:0] ^ {2'b00, d};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mstate[k] = 0;
            msig[k]   = seed_of[k];
            mcnt[k]   = 0;
        end
    endtask

    task automatic model_step(input int k, input logic st, input logic dv,
                              input logic [1:0] d, input logic [1:0] msk);
        if (mstate[k] == 1) begin
            if (dv) begin
                msig[k] = mstep(msig[k], d & ~msk);
                mcnt[k] = mcnt[k] + 1;
                if (mcnt[k] == np_of[k]) mstate[k] = 2;
            end
        end else if (st) begin
            msig[k]   = seed_of[k];
            mcnt[k]   = 0;
            mstate[k] = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sig0",  32'(sig0),  32'(msig[0]));
        chk("cnt0",  32'(cnt0),  32'(mcnt[0]));
        chk("busy0", 32'(busy0), 32'(mstate[0] == 1));
        chk("done0", 32'(done0), 32'(mstate[0] == 2));
        chk("pass0", 32'(pass0), 32'(mstate[0] == 2 && msig[0] == golden0));
        chk("sig1",  32'(sig1),  32'(msig[1]));
        chk("cnt1",  32'(cnt1),  32'(mcnt[1]));
        chk("busy1", 32'(busy1), 32'(mstate[1] == 1));
        chk("done1", 32'(done1), 32'(mstate[1] == 2));
        chk("pass1", 32'(pass1), 32'(mstate[1] == 2 && msig[1] == golden1));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(0, start0, dv0, din0, mask0);
        model_step(1, start1, dv1, din1, mask1);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        start0 = 0; dv0 = 0; din0 = '0;
        start1 = 0; dv1 = 0; din1 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_seq[4];
        logic [1:0] run_din[4];

        seed_of[0] = 4'b0000; np_of[0] = 4;
        seed_of[1] = 4'b0001; np_of[1] = 8;
        model_reset();

        // Reset state
        #12;
        check_all();
        reset = 1;

        // dut0: 4 x din=01 -> 0001,0011,0111,1111
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0011; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1111;
        start0 = 1; tick(); start0 = 0;
        for (int i = 0; i < 4; i++) begin
            dv0 = 1; din0 = 2'b01;
            tick();
            chk("plan1_sig", 32'(sig0), 32'(exp_seq[i]));
        end
        idle_inputs();
        chk("plan1_done", 32'(done0), 32'd1);
        golden0 = 4'b1111; #1; check_all();
        chk("plan1_pass", 32'(pass0), 32'd1);
        golden0 = 4'b1110; #1; check_all();
        chk("plan1_nopass", 32'(pass0), 32'd0);
        tick();

        // dut1: SEED=0001, din=00 -> 0010,0100,1000,0011
        exp_seq[0] = 4'b0010; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0011;
        start1 = 1; tick(); start1 = 0;
        for (int i = 0; i < 4; i++) begin
            dv1 = 1; din1 = 2'b00;
            tick();
            chk("taps_sig", 32'(sig1), 32'(exp_seq[i]));
        end
        idle_inputs();

        // dut1 restarted from DONE-less RUN is ignored; finish run, then gaps
        for (int c = 0; c < 64 && mstate[1] != 2; c++) begin
            dv1 = 1; din1 = 2'($urandom_range(0, 3)); tick();
        end
        idle_inputs();
        start1 = 1; tick(); start1 = 0;
        for (int c = 0; c < 64 && mstate[1] != 2; c++) begin
            dv1 = (c % 3 == 0); din1 = 2'($urandom_range(0, 3));
            tick();
        end
        idle_inputs();
        chk("gap_done", 32'(done1), 32'd1);
        chk("gap_cnt", 32'(cnt1), 32'd8);
        tick();

        // start in RUN ignored, then start in DONE with din_valid
        start0 = 1; tick(); start0 = 0;
        dv0 = 1; din0 = 2'b10; tick();
        start0 = 1; dv0 = 1; din0 = 2'b11; tick(); start0 = 0;
        chk("run_start_cnt", 32'(cnt0), 32'd2);
        for (int c = 0; c < 16 && mstate[0] != 2; c++) begin
            dv0 = 1; din0 = 2'($urandom_range(0, 3)); tick();
        end
        chk("run_start_done", 32'(done0), 32'd1);
        start0 = 1; dv0 = 1; din0 = 2'b11; tick();
        idle_inputs();
        chk("done_start_busy", 32'(busy0), 32'd1);
        chk("done_start_cnt", 32'(cnt0), 32'd0);
        chk("done_start_sig", 32'(sig0), 32'd0);
        chk("done_start_done", 32'(done0), 32'd0);

        // Abort at pattern 3 with async reset, then a clean rerun
        for (int i = 0; i < 4; i++) run_din[i] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            dv0 = 1; din0 = run_din[i]; tick();
        end
        idle_inputs();
        #2 reset = 0;
        #1 model_reset();
        chk("abort_sig", 32'(sig0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        check_all();
        #2 reset = 1;
        start0 = 1; tick(); start0 = 0;
        for (int i = 0; i < 4; i++) begin
            dv0 = 1; din0 = run_din[i]; tick();
        end
        idle_inputs();
        chk("rerun_done", 32'(done0), 32'd1);

`ifdef MISR_XMASK_EN
        start0 = 1; tick(); start0 = 0;
        for (int i = 0; i < 4; i++) begin
            dv0 = 1; din0 = 2'b01; mask0 = 2'b01; tick();
        end
        idle_inputs(); mask0 = '0;
        golden0 = 4'b0000; #1; check_all();
        chk("mask_sig", 32'(sig0), 32'd0);
        chk("mask_pass", 32'(pass0), 32'd1);
        tick();
`endif

        // Random runs on both DUTs
        for (int r = 0; r < 8; r++) begin
            start0 = 1; start1 = 1; tick();
            for (int c = 0; c < 24; c++) begin
                start0 = ($urandom_range(0, 9) == 0);
                start1 = ($urandom_range(0, 9) == 0);
                dv0 = $urandom_range(0, 1); din0 = 2'($urandom_range(0, 3));
                dv1 = $urandom_range(0, 1); din1 = 2'($urandom_range(0, 3));
                golden0 = $urandom_range(0, 1) ? msig[0] : 4'($urandom_range(0, 15));
                golden1 = $urandom_range(0, 1) ? msig[1] : 4'($urandom_range(0, 15));
                tick();
            end
            idle_inputs();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
